// File: rtl/cache_way_array.sv
// One way of a set-associative cache: tag/valid/dirty/age per set, multi-word lines,
// registered lookup with byte-enabled write-on-hit, dirty-line eviction and word-serial fill.
module cache_way_array #(
  parameter int NUM_SETS      = 16,
  parameter int NUM_WAYS      = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lookup_valid,
  input  logic [ADDRESS_WIDTH-1:0]      lookup_addr,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH/8-1:0]       wr_be,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          hit,
  output logic [DATA_WIDTH-1:0]         hit_data,
  output logic                          hit_dirty,
  output logic [COUNTER_WIDTH-1:0]      my_age,
  output logic                          expired,
  input  logic                          age_update,
  input  logic [$clog2(NUM_SETS)-1:0]   age_index,
  input  logic                          age_accessed,
  input  logic [COUNTER_WIDTH-1:0]      accessed_way_age,
  input  logic                          fill_start,
  input  logic [ADDRESS_WIDTH-1:0]      fill_addr,
  input  logic                          fill_word_valid,
  input  logic [DATA_WIDTH-1:0]         fill_word_data,
  output logic                          fill_done,
  output logic                          evict_valid,
  input  logic                          evict_ready,
  output logic [ADDRESS_WIDTH-1:0]      evict_addr,
  output logic [DATA_WIDTH-1:0]         evict_data,
  output logic                          busy,
  output logic [1:0]                    fsm_state
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int WORDS   = BLOCK_SIZE / BYTES;
  localparam int BYTE_W  = $clog2(BYTES);
  localparam int WORD_W  = $clog2(WORDS);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDRESS_WIDTH - INDEX_W - WORD_W - BYTE_W;
  localparam logic [COUNTER_WIDTH-1:0] AGE_MAX = COUNTER_WIDTH'(NUM_WAYS - 1);
  localparam logic [WORD_W-1:0]        LAST_WORD = WORD_W'(WORDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVICT = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [TAG_W-1:0]         tag_q   [NUM_SETS];
  logic [COUNTER_WIDTH-1:0] age_q   [NUM_SETS];
  logic [DATA_WIDTH-1:0]    data_q  [NUM_SETS*WORDS];
  logic [NUM_SETS-1:0]      valid_q;
  logic [NUM_SETS-1:0]      dirty_q;

  logic [1:0]               state;
  logic [WORD_W-1:0]        cnt;
  logic [INDEX_W-1:0]       f_idx;
  logic [TAG_W-1:0]         f_tag;
  logic [TAG_W-1:0]         old_tag;

  logic [TAG_W-1:0]         lk_tag;
  logic [INDEX_W-1:0]       lk_idx;
  logic [WORD_W-1:0]        lk_word;
  logic [TAG_W-1:0]         fa_tag;
  logic [INDEX_W-1:0]       fa_idx;
  logic                     idle;
  logic                     lk_match;
  logic                     lk_fire;
  logic                     wr_fire;
  logic                     fill_wr;
  logic                     last_fill;
  logic                     unused_bits;

  assign lk_tag    = lookup_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign lk_idx    = lookup_addr[BYTE_W+WORD_W +: INDEX_W];
  assign lk_word   = lookup_addr[BYTE_W +: WORD_W];
  assign fa_tag    = fill_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign fa_idx    = fill_addr[BYTE_W+WORD_W +: INDEX_W];
  assign unused_bits = ^{lookup_addr[BYTE_W-1:0], fill_addr[BYTE_W+WORD_W-1:0]};

  assign idle      = (state == IDLE);
  assign lk_match  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_fire   = lookup_valid && idle;
  assign wr_fire   = lk_fire && wr_en && lk_match;
  assign fill_wr   = (state == FILL) && fill_word_valid;
  assign last_fill = fill_wr && (cnt == LAST_WORD);

  // Eviction handshake: a word transfers on a cycle with evict_valid && evict_ready;
  // evict_data/evict_addr depend only on state, cnt and the latched line, so they hold while stalled.
  assign evict_valid = (state == EVICT);
  assign evict_data  = evict_valid ? data_q[{f_idx, cnt}] : '0;
  assign evict_addr  = evict_valid ? {old_tag, f_idx, {(WORD_W+BYTE_W){1'b0}}} : '0;
  assign fill_done   = (state == DONE);
  assign busy        = !idle;
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      f_idx   <= '0;
      f_tag   <= '0;
      old_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start) begin
            f_idx   <= fa_idx;
            f_tag   <= fa_tag;
            old_tag <= tag_q[fa_idx];
            cnt     <= '0;
            state   <= (valid_q[fa_idx] && dirty_q[fa_idx]) ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (evict_ready) begin
            if (cnt == LAST_WORD) begin
              cnt   <= '0;
              state <= FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (fill_word_valid) begin
            if (cnt == LAST_WORD) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The target line is invalidated on fill_start so a partially filled line never looks valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_fire) dirty_q[lk_idx] <= 1'b1;
      if (idle && fill_start) valid_q[fa_idx] <= 1'b0;
      if (last_fill) begin
        valid_q[f_idx] <= 1'b1;
        dirty_q[f_idx] <= 1'b0;
      end
    end
  end

  // A completing fill resets its set's age, overriding any broadcast in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) age_q[s] <= AGE_MAX;
    end else begin
      if (age_update) begin
        if (age_accessed)
          age_q[age_index] <= '0;
        else if ((age_q[age_index] < accessed_way_age) && (age_q[age_index] < AGE_MAX))
          age_q[age_index] <= age_q[age_index] + 1'b1;
      end
      if (last_fill) age_q[f_idx] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++)
        if (wr_be[b]) data_q[{lk_idx, lk_word}][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (fill_wr) data_q[{f_idx, cnt}] <= fill_word_data;
    if (last_fill) tag_q[f_idx] <= f_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit       <= 1'b0;
      hit_data  <= '0;
      hit_dirty <= 1'b0;
      my_age    <= '0;
      expired   <= 1'b0;
    end else begin
      hit <= lk_fire && lk_match;
      if (lk_fire) begin
        hit_data  <= data_q[{lk_idx, lk_word}];
        hit_dirty <= dirty_q[lk_idx];
        my_age    <= age_q[lk_idx];
        expired   <= !valid_q[lk_idx] || (age_q[lk_idx] == AGE_MAX);
      end
    end
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array: reset, clean fill, write-on-hit, stalled eviction,
// age saturation and reset during a fill.
module tb_cache_way_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        hit;
  logic [31:0] hit_data;
  logic        hit_dirty;
  logic [7:0]  my_age;
  logic        expired;
  logic        age_update = 1'b0;
  logic [3:0]  age_index = '0;
  logic        age_accessed = 1'b0;
  logic [7:0]  accessed_way_age = '0;
  logic        fill_start = 1'b0;
  logic [31:0] fill_addr = '0;
  logic        fill_word_valid = 1'b0;
  logic [31:0] fill_word_data = '0;
  logic        fill_done;
  logic        evict_valid;
  logic        evict_ready = 1'b0;
  logic [31:0] evict_addr;
  logic [31:0] evict_data;
  logic        busy;
  logic [1:0]  fsm_state;

  int passed = 0;
  int total  = 0;

  cache_way_array dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .hit(hit), .hit_data(hit_data), .hit_dirty(hit_dirty),
    .my_age(my_age), .expired(expired),
    .age_update(age_update), .age_index(age_index),
    .age_accessed(age_accessed), .accessed_way_age(accessed_way_age),
    .fill_start(fill_start), .fill_addr(fill_addr),
    .fill_word_valid(fill_word_valid), .fill_word_data(fill_word_data),
    .fill_done(fill_done), .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data), .busy(busy),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input logic [22:0] tag, input logic [3:0] idx,
                                          input logic [2:0] word);
    return {tag, idx, word, 2'b00};
  endfunction

  task automatic do_lookup(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    lookup_valid = 1'b1; lookup_addr = addr; wr_en = we; wr_be = be; wr_data = wd;
    tick();
    lookup_valid = 1'b0; wr_en = 1'b0; wr_be = '0; wr_data = '0;
  endtask

  task automatic age_pulse(input logic [3:0] idx, input logic acc, input logic [7:0] aw);
    age_update = 1'b1; age_index = idx; age_accessed = acc; accessed_way_age = aw;
    tick();
    age_update = 1'b0; age_accessed = 1'b0; accessed_way_age = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (hit !== 1'b0) $display("FAIL rst_hit: got %b want 0", hit); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (fill_done !== 1'b0) $display("FAIL rst_fill_done: got %b want 0", fill_done); else passed++;
    total++; if (evict_valid !== 1'b0) $display("FAIL rst_evict_valid: got %b want 0", evict_valid); else passed++;
    total++; if (evict_addr !== 32'h0) $display("FAIL rst_evict_addr: got %h want 0", evict_addr); else passed++;
    total++; if (my_age !== 8'd0) $display("FAIL rst_my_age: got %0d want 0", my_age); else passed++;
    total++; if (expired !== 1'b0) $display("FAIL rst_expired: got %b want 0", expired); else passed++;
    rst_n = 1'b1;
    tick();
    do_lookup(32'h0000_0040, 1'b0, 4'h0, 32'h0);
    total++; if (hit !== 1'b0) $display("FAIL cold_hit: got %b want 0", hit); else passed++;
    total++; if (expired !== 1'b1) $display("FAIL cold_expired: got %b want 1", expired); else passed++;
    total++; if (my_age !== 8'd3) $display("FAIL cold_my_age: got %0d want 3", my_age); else passed++;
  endtask

  task automatic test_clean_fill();
    fill_start = 1'b1; fill_addr = mk_addr(23'h1234, 4'd2, 3'd0);
    tick();
    fill_start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL cf_busy: got %b want 1", busy); else passed++;
    for (int i = 0; i < 8; i++) begin
      fill_word_valid = 1'b1; fill_word_data = 32'hA0 + i;
      tick();
      fill_word_valid = 1'b0;
      total++;
      if (evict_valid !== 1'b0 || fill_done !== (i == 7))
        $display("FAIL cf_word%0d: evict_valid=%b fill_done=%b want 0/%b", i, evict_valid, fill_done, i == 7);
      else passed++;
      if (i % 2 == 1 && i < 7) tick();
    end
    tick();
    total++; if (fill_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL cf_after: fill_done=%b busy=%b want 0/0", fill_done, busy); else passed++;
    do_lookup(mk_addr(23'h1234, 4'd2, 3'd5), 1'b0, 4'h0, 32'h0);
    total++; if (hit !== 1'b1) $display("FAIL cf_hit: got %b want 1", hit); else passed++;
    total++; if (hit_data !== 32'hA5) $display("FAIL cf_data: got %h want 000000a5", hit_data); else passed++;
    total++; if (hit_dirty !== 1'b0) $display("FAIL cf_dirty: got %b want 0", hit_dirty); else passed++;
    total++; if (my_age !== 8'd0 || expired !== 1'b0)
      $display("FAIL cf_age: my_age=%0d expired=%b want 0/0", my_age, expired); else passed++;
  endtask

  task automatic test_write_hit();
    do_lookup(mk_addr(23'h1234, 4'd2, 3'd5), 1'b1, 4'b0011, 32'hFFFF_BEEF);
    total++; if (hit !== 1'b1 || hit_data !== 32'hA5 || hit_dirty !== 1'b0)
      $display("FAIL wr_prewrite: hit=%b data=%h dirty=%b want 1/000000a5/0", hit, hit_data, hit_dirty); else passed++;
    do_lookup(mk_addr(23'h1234, 4'd2, 3'd5), 1'b0, 4'h0, 32'h0);
    total++; if (hit_data !== 32'h0000_BEEF) $display("FAIL wr_data: got %h want 0000beef", hit_data); else passed++;
    total++; if (hit_dirty !== 1'b1) $display("FAIL wr_dirty: got %b want 1", hit_dirty); else passed++;
    do_lookup(mk_addr(23'h1235, 4'd2, 3'd5), 1'b1, 4'hF, 32'h1234_5678);
    total++; if (hit !== 1'b0) $display("FAIL wr_miss_hit: got %b want 0", hit); else passed++;
    do_lookup(mk_addr(23'h1234, 4'd2, 3'd5), 1'b0, 4'h0, 32'h0);
    total++; if (hit_data !== 32'h0000_BEEF) $display("FAIL wr_miss_data: got %h want 0000beef", hit_data); else passed++;
    do_lookup(mk_addr(23'h1234, 4'd2, 3'd4), 1'b0, 4'h0, 32'h0);
    total++; if (hit_data !== 32'hA4) $display("FAIL wr_neighbour: got %h want 000000a4", hit_data); else passed++;
  endtask

  task automatic test_evict();
    logic [31:0] exp_words [8];
    logic [31:0] exp_addr;
    for (int i = 0; i < 8; i++) exp_words[i] = 32'hA0 + i;
    exp_words[5] = 32'h0000_BEEF;
    exp_addr = mk_addr(23'h1234, 4'd2, 3'd0);
    fill_start = 1'b1; fill_addr = mk_addr(23'h0777, 4'd2, 3'd0);
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      evict_ready = 1'b0;
      total++; if (evict_valid !== 1'b1 || evict_data !== exp_words[k] || evict_addr !== exp_addr)
        $display("FAIL ev_word%0d: valid=%b data=%h addr=%h want 1/%h/%h", k, evict_valid, evict_data, evict_addr, exp_words[k], exp_addr);
      else passed++;
      if (k == 0) begin
        lookup_valid = 1'b1; lookup_addr = exp_addr; wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h0;
      end
      tick();
      if (k == 0) begin
        lookup_valid = 1'b0; wr_en = 1'b0; wr_be = '0;
        total++; if (hit !== 1'b0) $display("FAIL ev_busy_hit: got %b want 0", hit); else passed++;
      end
      total++; if (evict_valid !== 1'b1 || evict_data !== exp_words[k])
        $display("FAIL ev_stall%0d: valid=%b data=%h want 1/%h", k, evict_valid, evict_data, exp_words[k]);
      else passed++;
      evict_ready = 1'b1;
      tick();
    end
    evict_ready = 1'b0;
    total++; if (evict_valid !== 1'b0 || busy !== 1'b1 || fill_done !== 1'b0)
      $display("FAIL ev_to_fill: evict_valid=%b busy=%b fill_done=%b want 0/1/0", evict_valid, busy, fill_done);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      fill_word_valid = 1'b1; fill_word_data = 32'hB0 + i;
      if (i == 7) begin
        age_update = 1'b1; age_index = 4'd2; age_accessed = 1'b0; accessed_way_age = 8'd3;
      end
      tick();
    end
    fill_word_valid = 1'b0; age_update = 1'b0; accessed_way_age = '0;
    total++; if (fill_done !== 1'b1) $display("FAIL ev_fill_done: got %b want 1", fill_done); else passed++;
    tick();
    do_lookup(mk_addr(23'h0777, 4'd2, 3'd3), 1'b0, 4'h0, 32'h0);
    total++; if (hit !== 1'b1 || hit_data !== 32'hB3 || hit_dirty !== 1'b0)
      $display("FAIL ev_newline: hit=%b data=%h dirty=%b want 1/000000b3/0", hit, hit_data, hit_dirty); else passed++;
    total++; if (my_age !== 8'd0) $display("FAIL ev_age_collision: got %0d want 0", my_age); else passed++;
    do_lookup(exp_addr, 1'b0, 4'h0, 32'h0);
    total++; if (hit !== 1'b0) $display("FAIL ev_oldline: got %b want 0", hit); else passed++;
  endtask

  task automatic test_age();
    logic [7:0] aw_seq  [8];
    logic       acc_seq [8];
    logic [3:0] idx_seq [8];
    logic [7:0] exp_age [8];
    aw_seq  = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd200, 8'd0, 8'd0};
    acc_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    idx_seq = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd4, 4'd2};
    exp_age = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0};
    for (int i = 0; i < 8; i++) begin
      age_pulse(idx_seq[i], acc_seq[i], aw_seq[i]);
      do_lookup(mk_addr(23'h0777, 4'd2, 3'd0), 1'b0, 4'h0, 32'h0);
      total++; if (my_age !== exp_age[i] || expired !== (exp_age[i] == 8'd3))
        $display("FAIL age_step%0d: my_age=%0d expired=%b want %0d/%b", i, my_age, expired, exp_age[i], exp_age[i] == 8'd3);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_fill();
    fill_start = 1'b1; fill_addr = mk_addr(23'h0055, 4'd7, 3'd0);
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fill_word_valid = 1'b1; fill_word_data = 32'hC0 + i;
      tick();
    end
    fill_word_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || fill_done !== 1'b0 || evict_valid !== 1'b0)
      $display("FAIL rmf_async: busy=%b fill_done=%b evict_valid=%b want 0/0/0", busy, fill_done, evict_valid); else passed++;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b0 || fill_done !== 1'b0)
      $display("FAIL rmf_after: busy=%b fill_done=%b want 0/0", busy, fill_done); else passed++;
    do_lookup(mk_addr(23'h0055, 4'd7, 3'd0), 1'b0, 4'h0, 32'h0);
    total++; if (hit !== 1'b0 || expired !== 1'b1)
      $display("FAIL rmf_partial: hit=%b expired=%b want 0/1", hit, expired); else passed++;
    do_lookup(mk_addr(23'h0777, 4'd2, 3'd3), 1'b0, 4'h0, 32'h0);
    total++; if (hit !== 1'b0 || my_age !== 8'd3)
      $display("FAIL rmf_oldset: hit=%b my_age=%0d want 0/3", hit, my_age); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_fill();
    test_write_hit();
    test_evict();
    test_age();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
